// File: rtl/uart_txrx_fifo_core.sv
// UART engine: serial transmitter, serial receiver with 2-FF synchroniser and a show-ahead RX FIFO.
// Frame format (baud divisor, parity, stop bits) is captured at the start of each frame.
module uart_txrx_fifo_core #(
  parameter int DATA_BITS     = 8,
  parameter int DIV_WIDTH     = 16,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DIV_WIDTH-1:0]             baud_div,
  input  logic [1:0]                       parity_mode,
  input  logic                             two_stop,
  input  logic [DATA_BITS-1:0]             tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx_busy,
  output logic                             txd,
  input  logic                             rxd,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overrun_err,
  input  logic                             err_clear,
  output logic [2:0]                       tx_state_dbg,
  output logic [2:0]                       rx_state_dbg
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] ONE_DIV  = DIV_WIDTH'(1);
  localparam logic [3:0]           LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_WAIT   = 3'd5
  } rx_state_t;

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 par_en;

  assign eff_div = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
  assign par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_en_q, tx_par_en_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_two_q, tx_two_d;
  logic                 txd_q, txd_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_div_q - ONE_DIV);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid/data must stay stable until then, ready never depends combinationally on valid.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_en_d = tx_par_en_q;
    tx_par_d    = tx_par_q;
    tx_two_d    = tx_two_q;
    txd_d       = txd_q;
    tx_ready_d  = tx_ready_q;
    tx_busy_d   = tx_busy_q;
    if (tx_state_q == TX_IDLE) begin
      if (tx_valid && tx_ready_q) begin
        tx_state_d  = TX_START;
        tx_cnt_d    = '0;
        tx_div_d    = eff_div;
        tx_shift_d  = tx_data;
        tx_par_en_d = par_en;
        tx_par_d    = (^tx_data) ^ parity_mode[1];
        tx_two_d    = two_stop;
        txd_d       = 1'b0;
        tx_ready_d  = 1'b0;
        tx_busy_d   = 1'b1;
      end
    end else if (!tx_bit_end) begin
      tx_cnt_d = tx_cnt_q + ONE_DIV;
    end else begin
      tx_cnt_d = '0;
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
        TX_DATA: begin
          if (tx_bit_q == LAST_BIT) begin
            tx_bit_d = '0;
            if (tx_par_en_q) begin
              tx_state_d = TX_PARITY;
              txd_d      = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              txd_d      = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
        TX_PARITY: begin
          tx_state_d = TX_STOP;
          tx_bit_d   = '0;
          txd_d      = 1'b1;
        end
        TX_STOP: begin
          if (tx_two_q && (tx_bit_q == 4'd0)) begin
            tx_bit_d = 4'd1;
          end else begin
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
            txd_d      = 1'b1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= MIN_DIV;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_two_q    <= 1'b0;
      txd_q       <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_en_q <= tx_par_en_d;
      tx_par_q    <= tx_par_d;
      tx_two_q    <= tx_two_d;
      txd_q       <= txd_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_en_q, rx_par_en_d;
  logic                 rx_par_odd_q, rx_par_odd_d;
  logic                 push_q, push_d;
  logic                 frame_set, parity_set;
  logic                 rx_bit_end, rx_half_end;

  assign rx_bit_end  = (rx_cnt_q == rx_div_q - ONE_DIV);
  assign rx_half_end = (rx_cnt_q == (rx_div_q >> 1) - ONE_DIV);

  always_comb begin
    rx_s1_d      = rxd;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    push_d       = 1'b0;
    frame_set    = 1'b0;
    parity_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d   = RX_START;
          rx_cnt_d     = '0;
          rx_div_d     = eff_div;
          rx_par_en_d  = par_en;
          rx_par_odd_d = parity_mode[1];
        end
      end
      RX_START: begin
        if (rx_half_end) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE_DIV;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + ONE_DIV;
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
          parity_set = (^rx_shift_q) ^ rx_s2_q ^ rx_par_odd_q;
        end else begin
          rx_cnt_d = rx_cnt_q + ONE_DIV;
        end
      end
      RX_STOP: begin
        // Only the first stop bit is sampled; a second one just looks like idle line.
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            push_d     = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_set  = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + ONE_DIV;
        end
      end
      RX_WAIT: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_div_q     <= MIN_DIV;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      push_q       <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
      push_q       <= push_d;
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 pop, full, push_ok, overrun_set;

  assign pop         = (count_q != '0) && rx_ready;
  assign full        = (count_q == CW'(RX_FIFO_DEPTH));
  assign push_ok     = push_q && (!full || pop);
  assign overrun_set = push_q && full && !pop;

  always_comb begin
    wr_ptr_d      = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push_ok) - CW'(pop);
    frame_err_d   = err_clear ? 1'b0 : (frame_err_q | frame_set);
    parity_err_d  = err_clear ? 1'b0 : (parity_err_q | parity_set);
    overrun_err_d = err_clear ? 1'b0 : (overrun_err_q | overrun_set);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  assign tx_ready     = tx_ready_q;
  assign tx_busy      = tx_busy_q;
  assign txd          = txd_q;
  assign rx_data      = mem_q[rd_ptr_q];
  assign rx_valid     = (count_q != '0);
  assign rx_count     = count_q;
  assign frame_err    = frame_err_q;
  assign parity_err   = parity_err_q;
  assign overrun_err  = overrun_err_q;
  assign tx_state_dbg = tx_state_q;
  assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_uart_txrx_fifo_core.sv
// Bench for uart_txrx_fifo_core: frame-level TX waveform model, queue model of the RX FIFO
// and sticky flags, checked every negedge, plus hand-computed literal expectations.
module tb_uart_txrx_fifo_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_busy, txd;
  logic        rxd, rxd_drv, loopback;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [4:0]  rx_count;
  logic        frame_err, parity_err, overrun_err, err_clear;
  logic [2:0]  tx_state_dbg, rx_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic       tx_exp_q[$];
  logic [7:0] exp_q[$];
  logic       fe_m, pe_m, ov_m;
  logic       tx_chk, rx_chk;
  logic       m_idle, m_txd;
  logic [7:0] tmp;

  assign rxd = loopback ? txd : rxd_drv;

  uart_txrx_fifo_core #(.DATA_BITS(8), .DIV_WIDTH(16), .RX_FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .txd(txd), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err), .err_clear(err_clear), .tx_state_dbg(tx_state_dbg),
    .rx_state_dbg(rx_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clock) begin
    if (!reset && tx_chk) begin
      m_idle = (tx_exp_q.size() == 0);
      m_txd  = m_idle ? 1'b1 : tx_exp_q.pop_front();
      chk("txd", txd, m_txd);
      chk("tx_ready", tx_ready, m_idle);
      chk("tx_busy", tx_busy, !m_idle);
    end
    if (!reset && rx_chk) begin
      chk("rx_count", rx_count, exp_q.size());
      chk("rx_valid", rx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("rx_data", rx_data, exp_q[0]);
      chk("frame_err", frame_err, fe_m);
      chk("parity_err", parity_err, pe_m);
      chk("overrun_err", overrun_err, ov_m);
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) ----------------
  task automatic tx_send(input logic [7:0] d);
    int b;
    int k;
    logic bits[$];
    k = 0;
    while (tx_exp_q.size() != 0 && k < 20000) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 20000) tmo("tx_send_wait");
    b = (baud_div < 16'd4) ? 4 : int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (parity_mode == 2'b01 || parity_mode == 2'b10)
      bits.push_back((^d) ^ (parity_mode == 2'b10));
    bits.push_back(1'b1);
    if (two_stop) bits.push_back(1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clock); #1;
    tx_valid = 1'b0;
    foreach (bits[i]) for (int j = 0; j < b; j++) tx_exp_q.push_back(bits[i]);
  endtask

  task automatic tx_drain();
    int k;
    k = 0;
    while (tx_exp_q.size() != 0 && k < 20000) begin
      @(posedge clock); #1;
      k++;
    end
    if (k >= 20000) tmo("tx_drain");
  endtask

  task automatic drive_bit(input logic v, input int n);
    rxd_drv = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] d, input int pm, input bit flip,
                          input logic stop_v, input int b);
    drive_bit(1'b0, b);
    for (int i = 0; i < 8; i++) drive_bit(d[i], b);
    if (pm == 1 || pm == 2) drive_bit((^d) ^ (pm == 2) ^ flip, b);
    drive_bit(stop_v, b);
    drive_bit(1'b1, 4 * b);
  endtask

  task automatic model_push(input logic [7:0] d);
    if (exp_q.size() < 16) exp_q.push_back(d);
    else ov_m = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(posedge clock);
    if (exp_q.size() != 0) tmp = exp_q.pop_front();
    #1 rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge clock);
    fe_m = 1'b0;
    pe_m = 1'b0;
    ov_m = 1'b0;
    #1 err_clear = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clock);
    #1 rx_chk = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] pat;
    int k;
    reset = 1'b1; baud_div = 16'd16; parity_mode = 2'b00; two_stop = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rxd_drv = 1'b1; loopback = 1'b0;
    rx_ready = 1'b0; err_clear = 1'b0; tx_chk = 1'b0; rx_chk = 1'b0;
    fe_m = 1'b0; pe_m = 1'b0; ov_m = 1'b0;

    #2;
    chk("rst_txd", txd, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_count", rx_count, 5'd0);
    chk("rst_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    chk("rst_fsm", {tx_state_dbg, rx_state_dbg}, 6'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tx_chk = 1'b1;
    rx_chk = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // TX 0x55, even parity, one stop, 16 clocks per bit
    baud_div = 16'd16; parity_mode = 2'b01; two_stop = 1'b0;
    pat = 11'b10010101010;
    tx_send(8'h55);
    for (k = 1; k <= 177; k++) begin
      @(negedge clock);
      if (k <= 176 && (k % 16) == 8) chk("t2_bit", txd, pat[k / 16]);
      if (k == 176) chk("t2_ready_176", tx_ready, 1'b0);
      if (k == 177) chk("t2_ready_177", tx_ready, 1'b1);
    end
    @(posedge clock); #1;

    // loopback, odd parity, two stop bits
    baud_div = 16'd8; parity_mode = 2'b10; two_stop = 1'b1;
    rx_chk = 1'b0;
    loopback = 1'b1;
    tx_send(8'h00);
    tx_send(8'hFF);
    tx_send(8'hA5);
    tx_drain();
    repeat (20) @(posedge clock); #1;
    model_push(8'h00); model_push(8'hFF); model_push(8'hA5);
    settle(1);
    @(negedge clock);
    chk("t3_count", rx_count, 5'd3);
    chk("t3_head", rx_data, 8'h00);
    chk("t3_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    @(posedge clock); #1;
    pop_one(); pop_one(); pop_one();
    loopback = 1'b0;
    repeat (4) @(posedge clock); #1;

    // 8-clock glitch with 32 clocks per bit: false start
    baud_div = 16'd32; parity_mode = 2'b00; two_stop = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    @(negedge clock);
    chk("t4_in_start", rx_state_dbg, 3'd1);
    repeat (60) @(posedge clock); #1;
    @(negedge clock);
    chk("t4_idle", rx_state_dbg, 3'd0);
    chk("t4_count", rx_count, 5'd0);
    chk("t4_errs", {frame_err, parity_err, overrun_err}, 3'b000);
    @(posedge clock); #1;

    // frame error, then parity error, then clear
    baud_div = 16'd8; parity_mode = 2'b01;
    rx_chk = 1'b0;
    rx_frame(8'h3C, 1, 1'b0, 1'b0, 8);
    fe_m = 1'b1;
    rx_frame(8'h5A, 1, 1'b1, 1'b1, 8);
    pe_m = 1'b1;
    model_push(8'h5A);
    settle(2);
    @(negedge clock);
    chk("t5_frame_err", frame_err, 1'b1);
    chk("t5_parity_err", parity_err, 1'b1);
    chk("t5_count", rx_count, 5'd1);
    chk("t5_head", rx_data, 8'h5A);
    @(posedge clock); #1;
    clear_errs();
    @(negedge clock);
    chk("t5_cleared", {frame_err, parity_err}, 2'b00);
    @(posedge clock); #1;
    pop_one();

    // overrun: 17 frames into a 16-deep FIFO
    baud_div = 16'd4; parity_mode = 2'b00;
    rx_chk = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rx_frame(8'(i * 17 + 1), 0, 1'b0, 1'b1, 4);
      model_push(8'(i * 17 + 1));
    end
    settle(2);
    @(negedge clock);
    chk("t6_overrun", overrun_err, 1'b1);
    chk("t6_count", rx_count, 5'd16);
    chk("t6_head", rx_data, 8'h01);
    @(posedge clock); #1;
    clear_errs();
    rx_chk = 1'b0;
    fork
      rx_frame(8'hEE, 0, 1'b0, 1'b1, 4);
      begin
        int w;
        w = 0;
        while (rx_state_dbg != 3'd4 && w < 2000) begin @(negedge clock); w++; end
        if (w >= 2000) tmo("t6_wait_stop");
        w = 0;
        while (rx_state_dbg == 3'd4 && w < 200) begin @(negedge clock); w++; end
        if (w >= 200) tmo("t6_wait_stop_end");
        rx_ready = 1'b1;
        @(posedge clock);
        if (exp_q.size() != 0) tmp = exp_q.pop_front();
        #1 rx_ready = 1'b0;
      end
    join
    model_push(8'hEE);
    settle(2);
    @(negedge clock);
    chk("t6b_overrun", overrun_err, 1'b0);
    chk("t6b_count", rx_count, 5'd16);
    chk("t6b_head", rx_data, 8'h12);
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) pop_one();

    // reset in the middle of a TX frame with a byte in the FIFO
    baud_div = 16'd8;
    rx_chk = 1'b0;
    rx_frame(8'h77, 0, 1'b0, 1'b1, 8);
    model_push(8'h77);
    settle(2);
    @(negedge clock);
    chk("t1_pre_count", rx_count, 5'd1);
    @(posedge clock); #1;
    tx_send(8'hC3);
    repeat (30) @(posedge clock);
    @(negedge clock);
    #2;
    tx_chk = 1'b0;
    rx_chk = 1'b0;
    reset = 1'b1;
    #1;
    chk("t1_txd", txd, 1'b1);
    chk("t1_tx_ready", tx_ready, 1'b1);
    chk("t1_tx_busy", tx_busy, 1'b0);
    chk("t1_rx_count", rx_count, 5'd0);
    chk("t1_rx_valid", rx_valid, 1'b0);
    tx_exp_q.delete();
    exp_q.delete();
    fe_m = 1'b0; pe_m = 1'b0; ov_m = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    tx_chk = 1'b1;
    rx_chk = 1'b1;
    repeat (5) @(posedge clock); #1;
    tx_send(8'h3A);
    tx_drain();
    repeat (10) @(posedge clock); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
